// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, read-select
// constants and default latencies.
package mdu_defs;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  localparam logic RSEL_LO = 1'b0;
  localparam logic RSEL_HI = 1'b1;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are captured at start; the result is computed from the captured
// operands and committed to HI/LO when the latency counter expires.
module mdu
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDU_Start,
  input  logic [2:0]  MDU_Op,
  input  logic [31:0] MDU_A,
  input  logic [31:0] MDU_B,
  input  logic        MDU_RSel,
  output logic [31:0] MDU_RData,
  output logic        MDU_Busy,
  output logic        MDU_Stall,
  output logic [31:0] MDU_HI,
  output logic [31:0] MDU_LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic [31:0]     hi_q, lo_q;
  mdu_op_e         op_q;
  logic [31:0]     a_q, b_q;

  logic [63:0]        res;
  logic               div_by_zero;
  logic               div_ovf;
  logic [63:0]        prod_s, prod_u;
  logic signed [63:0] a_sx, b_sx;
  logic signed [31:0] a_s, b_s_safe, quot_s, rem_s;
  logic [31:0]        b_u_safe, quot_u, rem_u;

  // Arithmetic on the captured operands; divisors are steered to 1 in the
  // zero and overflow cases so the divider never sees an undefined input.
  assign div_by_zero = (b_q == 32'h0);
  assign div_ovf     = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'h0, a_q} * {32'h0, b_q};

  assign a_s        = a_q;
  assign b_s_safe   = (div_by_zero || div_ovf) ? 32'sd1 : b_q;
  assign quot_s     = a_s / b_s_safe;
  assign rem_s      = a_s % b_s_safe;
  assign b_u_safe   = div_by_zero ? 32'd1 : b_q;
  assign quot_u     = a_q / b_u_safe;
  assign rem_u      = a_q % b_u_safe;

  // Select the pending {hi, lo} for the in-flight op.
  always_comb begin
    res = 64'h0;
    case (op_q)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV:   res = div_ovf ? {32'h0, 32'h8000_0000} : {rem_s, quot_s};
      MDU_DIVU:  res = {rem_u, quot_u};
      default:   res = 64'h0;
    endcase
  end

  // Control FSM: launch, count down, commit; reset discards any pending op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      op_q    <= MDU_NONE;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (MDU_Start) begin
            if (is_long_op(MDU_Op)) begin
              op_q    <= mdu_op_e'(MDU_Op);
              a_q     <= MDU_A;
              b_q     <= MDU_B;
              cnt_q   <= ((MDU_Op == MDU_MULT) || (MDU_Op == MDU_MULTU)) ?
                         CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state_q <= StBusy;
            end else if (MDU_Op == MDU_MTHI) begin
              hi_q <= MDU_A;
            end else if (MDU_Op == MDU_MTLO) begin
              lo_q <= MDU_A;
            end
          end
        end
        StBusy: begin
          // Starts are dropped here; the controller is expected to stall.
          if (cnt_q <= CntW'(1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
            // A zero divisor leaves HI/LO untouched.
            if (!(((op_q == MDU_DIV) || (op_q == MDU_DIVU)) && div_by_zero)) begin
              hi_q <= res[63:32];
              lo_q <= res[31:0];
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign MDU_Busy  = busy_q;
  assign MDU_Stall = busy_q | (MDU_Start & is_long_op(MDU_Op));
  assign MDU_RData = (MDU_RSel == RSEL_HI) ? hi_q : lo_q;
  assign MDU_HI    = hi_q;
  assign MDU_LO    = lo_q;

endmodule
